// File: rtl/demux1_4_stream_if.sv
// Stream bus for the 1-to-4 demultiplexer: one select-tagged input stream and
// four independent output channels.
interface demux1_4_stream_if #(
  parameter int unsigned W = 2
);
  logic         s_valid;
  logic         s_ready;
  logic [1:0]   s_sel;
  logic [W-1:0] s_data;
  logic [3:0]   m_valid;
  logic [3:0]   m_ready;
  logic [W-1:0] m_data0;
  logic [W-1:0] m_data1;
  logic [W-1:0] m_data2;
  logic [W-1:0] m_data3;

  // Producer and consumers side.
  modport master (
    output s_valid, s_sel, s_data, m_ready,
    input  s_ready, m_valid, m_data0, m_data1, m_data2, m_data3
  );

  // Demultiplexer side.
  modport slave (
    input  s_valid, s_sel, s_data, m_ready,
    output s_ready, m_valid, m_data0, m_data1, m_data2, m_data3
  );
endinterface

// File: rtl/demux1_4_stream.sv
// 1-to-4 stream demultiplexer with one registered output slot per channel and
// a wrapping delivered-word counter per channel.
module demux1_4_stream #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  demux1_4_stream_if.slave bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0]       valid_q, valid_d;
  logic [3:0]       drain;
  logic             s_ready;
  logic             acc;
  logic [W-1:0]     data_q [4];
  logic [W-1:0]     data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];

  always_comb begin
    drain   = valid_q & bus.m_ready;
    // Only the addressed channel gates the input, so a stalled channel never
    // blocks traffic to the others.
    s_ready = ~rst & (~valid_q[bus.s_sel] | bus.m_ready[bus.s_sel]);
    acc     = bus.s_valid & s_ready;
    valid_d = valid_q & ~drain;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i] + CNT_W'(drain[i]);
    end
    if (acc) begin
      valid_d[bus.s_sel] = 1'b1;
      data_d[bus.s_sel]  = bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = valid_q;
  assign bus.m_data0 = data_q[0];
  assign bus.m_data1 = data_q[1];
  assign bus.m_data2 = data_q[2];
  assign bus.m_data3 = data_q[3];
  assign cnt0        = cnt_q[0];
  assign cnt1        = cnt_q[1];
  assign cnt2        = cnt_q[2];
  assign cnt3        = cnt_q[3];

endmodule

// File: tb/tb_demux1_4_stream.sv
// Scoreboard bench for demux1_4_stream: directed scenarios followed by random
// traffic, checked against a per-channel queue model.
module tb_demux1_4_stream;
  localparam int unsigned W     = 2;
  localparam int unsigned CNT_W = 2;

  typedef logic [W-1:0]     word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cnt_t cnt0, cnt1, cnt2, cnt3;

  demux1_4_stream_if #(.W(W)) bus ();

  demux1_4_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1),
    .cnt2 (cnt2),
    .cnt3 (cnt3)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: words accepted but not yet delivered, per channel, plus
  // the last word written into each channel and the delivered-word counts.
  word_t exp_q   [4][$];
  word_t exp_hold[4];
  cnt_t  exp_cnt [4];

  word_t m_data_v[4];
  cnt_t  cnt_v   [4];
  assign m_data_v[0] = bus.m_data0;
  assign m_data_v[1] = bus.m_data1;
  assign m_data_v[2] = bus.m_data2;
  assign m_data_v[3] = bus.m_data3;
  assign cnt_v[0]    = cnt0;
  assign cnt_v[1]    = cnt1;
  assign cnt_v[2]    = cnt2;
  assign cnt_v[3]    = cnt3;

  initial begin
    for (int i = 0; i < 4; i++) begin
      exp_hold[i] = '0;
      exp_cnt[i]  = '0;
    end
  end

  // Monitor: compares the outputs mid-cycle, then retires words the consumer
  // takes at the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic  exp_v;
      word_t exp_d;
      exp_v = (exp_q[i].size() != 0);
      exp_d = exp_v ? exp_q[i][0] : exp_hold[i];
      checks++;
      if (bus.m_valid[i] !== exp_v) begin
        failures++;
        $display("FAIL m_valid[%0d] t=%0t got=%b exp=%b", i, $time, bus.m_valid[i], exp_v);
      end
      checks++;
      if (m_data_v[i] !== exp_d) begin
        failures++;
        $display("FAIL m_data%0d t=%0t got=%0d exp=%0d", i, $time, m_data_v[i], exp_d);
      end
      checks++;
      if (cnt_v[i] !== exp_cnt[i]) begin
        failures++;
        $display("FAIL cnt%0d t=%0t got=%0d exp=%0d", i, $time, cnt_v[i], exp_cnt[i]);
      end
      if (exp_v && bus.m_ready[i]) begin
        void'(exp_q[i].pop_front());
        exp_cnt[i] = exp_cnt[i] + 1'b1;
      end
    end
  end

  // Drives one cycle of stimulus and reports whether the word is taken. The
  // channel has room if, after this cycle's delivery, nothing is left pending.
  task automatic step(input logic r, input logic v, input logic [1:0] sel, input word_t d,
                      input logic [3:0] mr, output logic acc);
    logic exp_rdy;
    @(posedge clk);
    #2;
    rst         = r;
    bus.s_valid = v;
    bus.s_sel   = sel;
    bus.s_data  = d;
    bus.m_ready = mr;
    @(negedge clk);
    #2;
    exp_rdy = !r && (exp_q[sel].size() == 0);
    checks++;
    if (bus.s_ready !== exp_rdy) begin
      failures++;
      $display("FAIL s_ready t=%0t sel=%0d got=%b exp=%b", $time, sel, bus.s_ready, exp_rdy);
    end
    acc = v && exp_rdy;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        exp_hold[i] = '0;
        exp_cnt[i]  = '0;
      end
    end else if (acc) begin
      exp_q[sel].push_back(d);
      exp_hold[sel] = d;
    end
  endtask

  initial begin
    logic        acc;
    logic        v;
    logic [1:0]  sel;
    word_t       d;
    logic [3:0]  mr;
    logic [1:0]  rr_sel [4];
    word_t       rr_dat [4];

    bus.s_valid = 1'b1;
    bus.s_sel   = 2'd0;
    bus.s_data  = '0;
    bus.m_ready = 4'b0000;

    // Reset held with a word offered.
    step(1'b1, 1'b1, 2'd1, 2'd3, 4'b1111, acc);
    step(1'b1, 1'b1, 2'd2, 2'd1, 4'b1111, acc);

    // Round-robin across all channels.
    rr_sel = '{2'd0, 2'd1, 2'd2, 2'd3};
    rr_dat = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rr_sel[i], rr_dat[i], 4'b1111, acc);
    repeat (2) step(1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, acc);

    // Channel 2 stalled; channel 0 traffic still flows.
    step(1'b0, 1'b1, 2'd2, 2'd3, 4'b1011, acc);
    step(1'b0, 1'b1, 2'd0, 2'd2, 4'b1011, acc);
    repeat (2) step(1'b0, 1'b1, 2'd2, 2'd1, 4'b1011, acc);
    step(1'b0, 1'b1, 2'd2, 2'd1, 4'b1111, acc);
    repeat (2) step(1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, acc);

    // Back-to-back into channel 1.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd1, word_t'(i), 4'b1111, acc);
    step(1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, acc);

    // Reset while channels 0 and 3 hold undelivered words.
    step(1'b0, 1'b1, 2'd0, 2'd1, 4'b0000, acc);
    step(1'b0, 1'b1, 2'd3, 2'd2, 4'b0000, acc);
    step(1'b1, 1'b0, 2'd0, 2'd0, 4'b0000, acc);
    step(1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, acc);

    // Counter wrap on channel 3.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd3, word_t'(i + 1), 4'b1111, acc);
    repeat (2) step(1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, acc);

    // Random traffic; an offered word is held until it is taken.
    acc = 1'b1;
    v   = 1'b0;
    sel = 2'd0;
    d   = '0;
    for (int n = 0; n < 600; n++) begin
      logic r;
      r = ($urandom_range(63) == 0);
      if (acc || !v || r) begin
        v   = ($urandom_range(3) != 0);
        sel = 2'($urandom_range(3));
        d   = word_t'($urandom);
      end
      mr = 4'($urandom);
      step(r, v, sel, d, mr, acc);
    end
    repeat (3) step(1'b0, 1'b0, 2'd0, 2'd0, 4'b1111, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
